// File: rtl/fpu_pipe_ctrl.sv
// Issue/execute/writeback control for a fixed-latency FP pipeline.
// Handles RAW hazard bubbles, operand forwarding selects and a global freeze for multicycle units.
module fpu_pipe_ctrl #(
    parameter int DEPTH = 3,
    parameter int WIDTH = 32,
    parameter int RW    = 5,
    parameter int CW    = 2
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             iv,
    input  logic [CW-1:0]    ic,
    input  logic             iw,
    input  logic [RW-1:0]    ifd,
    input  logic [RW-1:0]    ifs,
    input  logic [RW-1:0]    ift,
    input  logic             ufs,
    input  logic             uft,
    input  logic             mc_stall,
    input  logic [WIDTH-1:0] ed,
    output logic             e,
    output logic             iack,
    output logic             hz,
    output logic [CW-1:0]    ec,
    output logic [DEPTH-1:0] sw,
    output logic             ww,
    output logic [RW-1:0]    wn,
    output logic [WIDTH-1:0] wd,
    output logic [1:0]       fwa,
    output logic [1:0]       fwb,
    output logic [3:0]       occ
);

    // Index k-1 holds stage Ek.
    logic [DEPTH-1:0]         s_v;
    logic [DEPTH-1:0]         s_w;
    logic [DEPTH-1:0][CW-1:0] s_c;
    logic [DEPTH-1:0][RW-1:0] s_d;

    logic       haz_s;
    logic       haz_t;
    logic [3:0] occ_nxt;

    assign e = ~mc_stall;

    // Only E1..E<DEPTH-1> stall; the last stage is covered by the ed forward path.
    always_comb begin
        haz_s = 1'b0;
        haz_t = 1'b0;
        for (int k = 0; k < DEPTH - 1; k++) begin
            if (s_w[k] && (s_d[k] == ifs)) haz_s = 1'b1;
            if (s_w[k] && (s_d[k] == ift)) haz_t = 1'b1;
        end
    end

    assign hz   = iv & e & ((ufs & haz_s) | (uft & haz_t));
    assign iack = iv & e & ~hz;

    always_comb begin
        fwa = 2'd0;
        if (ufs) begin
            if (s_w[DEPTH-1] && (s_d[DEPTH-1] == ifs)) fwa = 2'd2;
            else if (ww && (wn == ifs))                fwa = 2'd1;
        end
    end

    always_comb begin
        fwb = 2'd0;
        if (uft) begin
            if (s_w[DEPTH-1] && (s_d[DEPTH-1] == ift)) fwb = 2'd2;
            else if (ww && (wn == ift))                fwb = 2'd1;
        end
    end

    // Next occupancy: incoming E1 plus everything shifting one place on (the last stage lands in writeback).
    always_comb begin
        occ_nxt = {3'b000, iack};
        for (int k = 0; k < DEPTH; k++) begin
            occ_nxt = occ_nxt + {3'b000, s_v[k]};
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            s_v <= '0;
            s_w <= '0;
            s_c <= '0;
            s_d <= '0;
            ww  <= 1'b0;
            wn  <= '0;
            wd  <= '0;
            occ <= '0;
        end else if (e) begin
            s_v[0] <= iack;
            s_w[0] <= iack & iw;
            s_c[0] <= iack ? ic  : '0;
            s_d[0] <= iack ? ifd : '0;
            for (int k = 1; k < DEPTH; k++) begin
                s_v[k] <= s_v[k-1];
                s_w[k] <= s_w[k-1];
                s_c[k] <= s_c[k-1];
                s_d[k] <= s_d[k-1];
            end
            ww  <= s_w[DEPTH-1];
            wn  <= s_d[DEPTH-1];
            wd  <= ed;
            occ <= occ_nxt;
        end
    end

    assign ec = s_c[DEPTH-1];
    assign sw = s_w;

endmodule

// File: tb/tb_fpu_pipe_ctrl.sv
// Bench for fpu_pipe_ctrl: DEPTH=3 and DEPTH=5 instances on shared stimulus,
// directed vectors plus random traffic against an age-based pipeline model.
module tb_fpu_pipe_ctrl;

    logic        clk = 1'b0;
    logic        clr;
    logic        iv, iw, ufs, uft, mc_stall;
    logic [1:0]  ic;
    logic [4:0]  ifd, ifs, ift;
    logic [31:0] ed;

    logic        e3, iack3, hz3, ww3;
    logic [1:0]  ec3, fwa3, fwb3;
    logic [2:0]  sw3;
    logic [4:0]  wn3;
    logic [31:0] wd3;
    logic [3:0]  occ3;

    logic        e5, iack5, hz5, ww5;
    logic [1:0]  ec5, fwa5, fwb5;
    logic [4:0]  sw5;
    logic [4:0]  wn5;
    logic [31:0] wd5;
    logic [3:0]  occ5;

    fpu_pipe_ctrl #(.DEPTH(3), .WIDTH(32), .RW(5), .CW(2)) u3 (
        .clk(clk), .clr(clr), .iv(iv), .ic(ic), .iw(iw), .ifd(ifd), .ifs(ifs), .ift(ift),
        .ufs(ufs), .uft(uft), .mc_stall(mc_stall), .ed(ed),
        .e(e3), .iack(iack3), .hz(hz3), .ec(ec3), .sw(sw3), .ww(ww3), .wn(wn3), .wd(wd3),
        .fwa(fwa3), .fwb(fwb3), .occ(occ3));

    fpu_pipe_ctrl #(.DEPTH(5), .WIDTH(32), .RW(5), .CW(2)) u5 (
        .clk(clk), .clr(clr), .iv(iv), .ic(ic), .iw(iw), .ifd(ifd), .ifs(ifs), .ift(ift),
        .ufs(ufs), .uft(uft), .mc_stall(mc_stall), .ed(ed),
        .e(e5), .iack(iack5), .hz(hz5), .ec(ec5), .sw(sw5), .ww(ww5), .wn(wn5), .wd(wd5),
        .fwa(fwa5), .fwb(fwb5), .occ(occ5));

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: each in-flight op carries its position (1..D = Ek, D+1 = writeback).
    int          m_pos[2][12];
    bit          m_w[2][12];
    int          m_c[2][12];
    int          m_d[2][12];
    logic [31:0] m_wd[2];

    function automatic int dep(int j);
        return (j == 0) ? 3 : 5;
    endfunction

    task automatic model_reset();
        for (int j = 0; j < 2; j++) begin
            m_wd[j] = '0;
            for (int i = 0; i < 12; i++) m_pos[j][i] = 0;
        end
    endtask

    function automatic bit m_haz(int j, int s);
        for (int i = 0; i < 12; i++)
            if (m_pos[j][i] >= 1 && m_pos[j][i] <= dep(j) - 1 && m_w[j][i] && m_d[j][i] == s) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int m_fw(int j, bit u, int s);
        if (!u) return 0;
        for (int i = 0; i < 12; i++)
            if (m_pos[j][i] == dep(j) && m_w[j][i] && m_d[j][i] == s) return 2;
        for (int i = 0; i < 12; i++)
            if (m_pos[j][i] == dep(j) + 1 && m_w[j][i] && m_d[j][i] == s) return 1;
        return 0;
    endfunction

    function automatic bit m_hz(int j);
        return iv && !mc_stall && ((ufs && m_haz(j, int'(ifs))) || (uft && m_haz(j, int'(ift))));
    endfunction

    function automatic bit m_iack(int j);
        return iv && !mc_stall && !m_hz(j);
    endfunction

    function automatic int m_sw(int j);
        int r = 0;
        for (int i = 0; i < 12; i++)
            if (m_pos[j][i] >= 1 && m_pos[j][i] <= dep(j) && m_w[j][i]) r |= 1 << (m_pos[j][i] - 1);
        return r;
    endfunction

    function automatic int m_at(int j, int pos, int what);
        for (int i = 0; i < 12; i++)
            if (m_pos[j][i] == pos) return (what == 0) ? m_c[j][i] : (what == 1) ? m_d[j][i] : int'(m_w[j][i]);
        return 0;
    endfunction

    function automatic int m_occ(int j);
        int n = 0;
        for (int i = 0; i < 12; i++) if (m_pos[j][i] > 0) n++;
        return n;
    endfunction

    task automatic model_edge(int j);
        bit acc;
        bit placed;
        if (mc_stall) return;
        acc = m_iack(j);
        for (int i = 0; i < 12; i++) begin
            if (m_pos[j][i] > 0) begin
                m_pos[j][i]++;
                if (m_pos[j][i] > dep(j) + 1) m_pos[j][i] = 0;
            end
        end
        m_wd[j] = ed;
        placed = 1'b0;
        if (acc) begin
            for (int i = 0; i < 12; i++) begin
                if (!placed && m_pos[j][i] == 0) begin
                    m_pos[j][i] = 1;
                    m_w[j][i]   = iw;
                    m_c[j][i]   = int'(ic);
                    m_d[j][i]   = int'(ifd);
                    placed      = 1'b1;
                end
            end
        end
    endtask

    task automatic check_dut(int j);
        string p;
        p = $sformatf("d%0d", dep(j));
        if (j == 0) begin
            chk({p, ".e"},    e3,    !mc_stall);
            chk({p, ".iack"}, iack3, m_iack(j));
            chk({p, ".hz"},   hz3,   m_hz(j));
            chk({p, ".ec"},   ec3,   m_at(j, dep(j), 0));
            chk({p, ".sw"},   sw3,   m_sw(j));
            chk({p, ".ww"},   ww3,   m_at(j, dep(j) + 1, 2));
            chk({p, ".wn"},   wn3,   m_at(j, dep(j) + 1, 1));
            chk({p, ".wd"},   wd3,   m_wd[j]);
            chk({p, ".fwa"},  fwa3,  m_fw(j, ufs, int'(ifs)));
            chk({p, ".fwb"},  fwb3,  m_fw(j, uft, int'(ift)));
            chk({p, ".occ"},  occ3,  m_occ(j));
        end else begin
            chk({p, ".e"},    e5,    !mc_stall);
            chk({p, ".iack"}, iack5, m_iack(j));
            chk({p, ".hz"},   hz5,   m_hz(j));
            chk({p, ".ec"},   ec5,   m_at(j, dep(j), 0));
            chk({p, ".sw"},   sw5,   m_sw(j));
            chk({p, ".ww"},   ww5,   m_at(j, dep(j) + 1, 2));
            chk({p, ".wn"},   wn5,   m_at(j, dep(j) + 1, 1));
            chk({p, ".wd"},   wd5,   m_wd[j]);
            chk({p, ".fwa"},  fwa5,  m_fw(j, ufs, int'(ifs)));
            chk({p, ".fwb"},  fwb5,  m_fw(j, uft, int'(ift)));
            chk({p, ".occ"},  occ5,  m_occ(j));
        end
    endtask

    task automatic idle();
        iv = 0; iw = 0; ic = '0; ifd = '0; ifs = '0; ift = '0;
        ufs = 0; uft = 0; mc_stall = 0; ed = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        clr = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        @(negedge clk);
        clr = 1'b0;
        model_reset();
    endtask

    typedef struct {
        bit          iv;
        logic [31:0] ed;
        logic [2:0]  sw3;
        int          occ3;
        bit          ww3;
        int          wn3;
        logic [4:0]  sw5;
        int          occ5;
        bit          ww5;
        int          wn5;
    } vec_t;

    vec_t tbl[7];

    int hz3_exp[7];
    int fw3_exp[7];
    int hz5_exp[7];
    int fw5_exp[7];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{1'b1, 32'h0000_0011, 3'b001, 1, 1'b0, 0, 5'b00001, 1, 1'b0, 0};
        tbl[1] = '{1'b0, 32'h0000_0022, 3'b010, 1, 1'b0, 0, 5'b00010, 1, 1'b0, 0};
        tbl[2] = '{1'b0, 32'h0000_0033, 3'b100, 1, 1'b0, 0, 5'b00100, 1, 1'b0, 0};
        tbl[3] = '{1'b0, 32'h0000_0044, 3'b000, 1, 1'b1, 4, 5'b01000, 1, 1'b0, 0};
        tbl[4] = '{1'b0, 32'h0000_0055, 3'b000, 0, 1'b0, 0, 5'b10000, 1, 1'b0, 0};
        tbl[5] = '{1'b0, 32'h0000_0066, 3'b000, 0, 1'b0, 0, 5'b00000, 1, 1'b1, 4};
        tbl[6] = '{1'b0, 32'h0000_0077, 3'b000, 0, 1'b0, 0, 5'b00000, 0, 1'b0, 0};
        hz3_exp = '{1, 1, 0, 0, 0, 0, 0};
        fw3_exp = '{0, 0, 2, 1, 0, 0, 0};
        hz5_exp = '{1, 1, 1, 1, 0, 0, 0};
        fw5_exp = '{0, 0, 0, 0, 2, 1, 0};

        // Reset state, sampled while clr is held.
        idle();
        clr = 1'b1;
        #12;
        chk("rst.sw3", sw3, 0);
        chk("rst.occ3", occ3, 0);
        chk("rst.ww3", ww3, 0);
        chk("rst.wn3", wn3, 0);
        chk("rst.wd3", wd3, 0);
        chk("rst.ec3", ec3, 0);
        chk("rst.occ5", occ5, 0);
        @(negedge clk);
        clr = 1'b0;

        // Single write op flowing to writeback.
        do_reset();
        iw = 1; ifd = 5'd4;
        for (int r = 0; r < 7; r++) begin
            iv = tbl[r].iv;
            ed = tbl[r].ed;
            tick();
            chk($sformatf("tbl%0d.sw3", r), sw3, tbl[r].sw3);
            chk($sformatf("tbl%0d.occ3", r), occ3, tbl[r].occ3);
            chk($sformatf("tbl%0d.ww3", r), ww3, tbl[r].ww3);
            chk($sformatf("tbl%0d.wn3", r), wn3, tbl[r].wn3);
            chk($sformatf("tbl%0d.wd3", r), wd3, tbl[r].ed);
            chk($sformatf("tbl%0d.sw5", r), sw5, tbl[r].sw5);
            chk($sformatf("tbl%0d.occ5", r), occ5, tbl[r].occ5);
            chk($sformatf("tbl%0d.ww5", r), ww5, tbl[r].ww5);
            chk($sformatf("tbl%0d.wn5", r), wn5, tbl[r].wn5);
        end

        // RAW hazard window then forwarding from ed, then from wd.
        do_reset();
        iv = 1; iw = 1; ifd = 5'd4;
        tick();
        iw = 0; ifd = 5'd0; ufs = 1; ifs = 5'd4; uft = 0; ift = 5'd4;
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            chk($sformatf("raw%0d.hz3", c), hz3, hz3_exp[c]);
            chk($sformatf("raw%0d.iack3", c), iack3, 1 - hz3_exp[c]);
            chk($sformatf("raw%0d.fwa3", c), fwa3, fw3_exp[c]);
            chk($sformatf("raw%0d.fwb3", c), fwb3, 0);
            chk($sformatf("raw%0d.hz5", c), hz5, hz5_exp[c]);
            chk($sformatf("raw%0d.fwa5", c), fwa5, fw5_exp[c]);
            tick();
        end

        // Freeze from the multicycle unit.
        do_reset();
        iv = 1; iw = 1;
        ifd = 5'd1; ic = 2'd1; ed = 32'h100; tick();
        ifd = 5'd2; ic = 2'd2; ed = 32'h200; tick();
        ifd = 5'd3; ic = 2'd3; ed = 32'h300; tick();
        mc_stall = 1; ifd = 5'd5; ufs = 1; ifs = 5'd3; ed = 32'hdead;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk($sformatf("stall%0d.e3", c), e3, 0);
            chk($sformatf("stall%0d.iack3", c), iack3, 0);
            chk($sformatf("stall%0d.hz3", c), hz3, 0);
            tick();
            chk($sformatf("stall%0d.sw3", c), sw3, 3'b111);
            chk($sformatf("stall%0d.occ3", c), occ3, 3);
            chk($sformatf("stall%0d.ec3", c), ec3, 1);
            chk($sformatf("stall%0d.ww3", c), ww3, 0);
            chk($sformatf("stall%0d.wd3", c), wd3, 32'h300);
            chk($sformatf("stall%0d.sw5", c), sw5, 5'b00111);
        end
        idle();
        ed = 32'h400;
        tick();
        chk("resume.sw3", sw3, 3'b110);
        chk("resume.occ3", occ3, 3);
        chk("resume.ww3", ww3, 1);
        chk("resume.wn3", wn3, 1);
        chk("resume.wd3", wd3, 32'h400);
        chk("resume.ec3", ec3, 2);
        chk("resume.sw5", sw5, 5'b01110);

        // Same destination in E1 and E3: the younger E1 match stalls.
        do_reset();
        iv = 1; iw = 1;
        ifd = 5'd7; tick();
        ifd = 5'd9; tick();
        ifd = 5'd7; tick();
        iw = 0; ifd = 5'd0; ufs = 1; ifs = 5'd7;
        @(negedge clk);
        chk("dual0.hz3", hz3, 1);
        chk("dual0.fwa3", fwa3, 2);
        tick();
        @(negedge clk);
        chk("dual1.hz3", hz3, 1);
        chk("dual1.fwa3", fwa3, 1);
        tick();
        @(negedge clk);
        chk("dual2.hz3", hz3, 0);
        chk("dual2.iack3", iack3, 1);
        chk("dual2.fwa3", fwa3, 2);

        // Asynchronous clear with a full pipe.
        do_reset();
        iv = 1; iw = 1; ifd = 5'd6; ic = 2'd2; ed = 32'h55;
        tick(); tick(); tick(); tick();
        chk("full.occ3", occ3, 4);
        chk("full.ww3", ww3, 1);
        chk("full.wn3", wn3, 6);
        #2;
        clr = 1'b1;
        #1;
        chk("aclr.sw3", sw3, 0);
        chk("aclr.occ3", occ3, 0);
        chk("aclr.ww3", ww3, 0);
        chk("aclr.wn3", wn3, 0);
        chk("aclr.wd3", wd3, 0);
        chk("aclr.ec3", ec3, 0);
        chk("aclr.occ5", occ5, 0);
        @(posedge clk);
        @(negedge clk);
        clr = 1'b0;
        iv = 1; iw = 0; ufs = 1; uft = 1; ifs = 5'd6; ift = 5'd6;
        #1;
        chk("post.hz3", hz3, 0);
        chk("post.iack3", iack3, 1);
        chk("post.fwa3", fwa3, 0);
        chk("post.fwb3", fwb3, 0);
        chk("post.hz5", hz5, 0);

        // Random traffic against the model, both depths.
        do_reset();
        for (int n = 0; n < 600; n++) begin
            iv       = ($urandom_range(0, 3) != 0);
            iw       = 1'($urandom_range(0, 1));
            ic       = 2'($urandom_range(0, 3));
            ifd      = 5'($urandom_range(0, 3));
            ifs      = 5'($urandom_range(0, 3));
            ift      = 5'($urandom_range(0, 3));
            ufs      = 1'($urandom_range(0, 1));
            uft      = 1'($urandom_range(0, 1));
            mc_stall = ($urandom_range(0, 5) == 0);
            ed       = $urandom;
            #1;
            check_dut(0);
            check_dut(1);
            @(posedge clk);
            model_edge(0);
            model_edge(1);
            @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fpu_pipe_ctrl.md
FPU_PIPE_CTRL -- requirements
Module: fpu_pipe_ctrl

Interface
REQ-001 Parameter DEPTH, default 3: number of fixed-latency execute stages (E1..E<DEPTH>); legal range 2..8.
REQ-002 Parameter WIDTH, default 32: result data width.
REQ-003 Parameter RW, default 5: register-number width.
REQ-004 Parameter CW, default 2: result-select code width.
REQ-005 clk  in  1  sole clock; all state updates on rising edge.
REQ-006 clr  in  1  reset, asynchronous, active-high.
REQ-007 iv  in  1  issue valid: an FP op is presented at the issue stage.
REQ-008 ic  in  CW  result-select code of the issuing op.
REQ-009 iw  in  1  issuing op writes the FP register file.
REQ-010 ifd  in  RW  destination register of the issuing op.
REQ-011 ifs, ift  in  RW each  source registers of the issuing op.
REQ-012 ufs, uft  in  1 each  source-in-use flags for ifs/ift.
REQ-013 mc_stall  in  1  multicycle unit (div/sqrt) requests a full freeze.
REQ-014 ed  in  WIDTH  selected unit result for the op in stage E<DEPTH>.
REQ-015 e  out  1  pipeline advance enable for all stages.
REQ-016 iack  out  1  issuing op accepted this cycle.
REQ-017 hz  out  1  RAW hazard stall (bubble) this cycle.
REQ-018 ec  out  CW  select code of stage E<DEPTH>, drives the external result mux.
REQ-019 sw  out  DEPTH  per-stage write flags, bit k-1 = stage Ek.
REQ-020 ww, wn, wd  out  1 / RW / WIDTH  writeback flag, register, data.
REQ-021 fwa, fwb  out  2 each  forward select for ifs/ift: 0 regfile, 1 wd, 2 ed.
REQ-022 occ  out  4  count of valid ops in E1..E<DEPTH> plus writeback stage.

Function
REQ-023 e SHALL equal ~mc_stall.
REQ-024 Stage Ek (k>=2) and writeback SHALL load from the preceding stage when e=1 and SHALL hold when e=0.
REQ-025 Writeback SHALL load ww<=sw[DEPTH-1], wn<=stage-DEPTH register, wd<=ed when e=1.
REQ-026 A source is hazardous when its use flag is set and it equals the destination of a stage Ek with write flag set, for k in 1..DEPTH-1.
REQ-027 hz SHALL equal iv & (any hazardous source) & e.
REQ-028 iack SHALL equal iv & e & ~hz.
REQ-029 When e=1, E1 SHALL load the issue fields if iack=1; otherwise it SHALL load a bubble (write flag 0, code 0, register 0).
REQ-030 During hz, stages E2..writeback SHALL still advance, so the hazard clears within DEPTH-1 cycles with no further issue.
REQ-031 fwa SHALL be 2 when ifs matches the stage-DEPTH destination with write flag set; otherwise 1 when it matches wn with ww=1; otherwise 0. fwb SHALL follow the same rule for ift. Unused sources SHALL give 0.
REQ-032 For register 0, matches SHALL be evaluated like any other register; no special case applies.
REQ-033 occ SHALL count the stage valid bits (iack captured, held through the pipe) of E1..E<DEPTH> and writeback, and SHALL update on the same edge as the stages.
REQ-034 When mc_stall and iv are asserted together, iack=0, hz=0, and no state SHALL change.
REQ-035 Combinational outputs hz, iack, fwa and fwb SHALL depend only on current inputs and state, with no combinational path from ed.

Reset
REQ-036 While clr=1, all stage registers, ww, wn, wd and occ SHALL be 0 and ec SHALL be 0, independent of clk.
REQ-037 A clr asserted mid-operation SHALL discard every in-flight op; the first edge after release SHALL behave as from empty.

Verification
REQ-038 DEPTH=3, clr pulse, then iv=1 iw=1 ifd=4 for one cycle, mc_stall=0 -> sw shows 001, 010, 100 on successive cycles, then ww=1 wn=4 wd=ed sampled at that edge; occ goes 1,1,1,1,0.
REQ-039 Issue writing f4, then next cycle iv=1 ufs=1 ifs=4 -> hz=1 and iack=0 for 2 cycles (E1, E2 match), then iack=1 with fwa=2; a further one-cycle delay gives fwa=1.
REQ-040 Three back-to-back ops, then mc_stall=1 for 5 cycles -> all sw/ww/wn/wd and occ frozen, e=0, iack=0 even with iv=1; resumes exactly where it stopped.
REQ-041 Ops writing f7 in E1 and in E3 together, ifs=7 -> hz=1 (E1 younger match dominates); after E1 and E2 drain -> fwa=2.
REQ-042 clr asserted with occ=4 -> immediate all-zero outputs; after release, issue proceeds with no stale hazard or forward.
REQ-043 Repeat REQ-038/039 at DEPTH=5 -> writeback 5 cycles after issue; hazard window 4 cycles.
